dmem_lsu: RTL
=============

# dmem_lsu

Data-memory load/store unit between the EX/MEM pipeline register and the data bus. Turns the memory operation held in EX/MEM into one aligned bus transaction (word address, byte masks, lane-shifted store data), tracks it to completion, and returns the raw word plus a held response strobe to the memory stage as its `dmem_rdata_i`/`dmem_resp_i`. The memory stage stalls the pipeline until `dmem_resp_o` is high, then extracts the bytes and sign-extends.

## Interface
- `ADDR_W`, default `ADDRW`: byte-address width.
- `DATA_W`, default `XLEN`: data width; only 32 is supported.
- `clk_i`  in  1: clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `req_valid_i`  in  1: EX/MEM holds a valid instruction.
- `req_is_load_i` / `req_is_store_i`  in  1 each: the instruction is a load / a store.
- `req_type_i`  in  3: funct3 size code (`FUNCT3_LS_B/BU/H/HU/W`).
- `req_addr_i`  in  ADDR_W: byte address.
- `req_wdata_i`  in  DATA_W: store data, unshifted, in the low bits.
- `advance_i`  in  1: EX/MEM loads new contents at this clock edge.
- `flush_i`  in  1: kill the instruction in EX/MEM.
- `bus_req_o`  out  1: request valid.
- `bus_ready_i`  in  1: request accepted.
- `bus_we_o`  out  1: 1 = write.
- `bus_addr_o`  out  ADDR_W: word-aligned address (bits [1:0] = 0).
- `bus_rmask_o`, `bus_wmask_o`  out  4: byte-lane read / write masks.
- `bus_wdata_o`  out  DATA_W: lane-replicated store data.
- `bus_rsp_valid_i`  in  1: response valid, one cycle.
- `bus_rsp_rdata_i`  in  DATA_W: read data, meaningful only for loads.
- `dmem_rdata_o`  out  DATA_W: captured response word.
- `dmem_resp_o`  out  1: operation complete; held until `advance_i`.
- `misalign_o`  out  1: misaligned-access flag, valid while `dmem_resp_o` is high.

## Operation
- **Reset values.**
  - All outputs are 0.
  - FSM is in IDLE and the `kill` flag is 0.
- **Operation detection.**
  - An operation is `req_valid_i && (req_is_load_i || req_is_store_i)`.
  - Assertion: `req_is_load_i` and `req_is_store_i` are never both high.
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE**
  - Operation present and `!flush_i`: register `bus_addr_o`, the masks, `bus_wdata_o` and `bus_we_o`; go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `bus_req_o` = 1. All request outputs stay stable until `bus_ready_i`.
  - On `bus_ready_i`: go to WAIT.
  - `flush_i` seen here sets `kill`. The request is never withdrawn.
- **WAIT**
  - A response may arrive in the same cycle as `bus_ready_i`; the FSM only samples it in WAIT.
  - On `bus_rsp_valid_i` with `kill` = 0: capture `bus_rsp_rdata_i` into `dmem_rdata_o`; go to DONE.
  - On `bus_rsp_valid_i` with `kill` = 1: discard the response, clear `kill`, go to IDLE.
  - `flush_i` seen here sets `kill`.
- **DONE**
  - `dmem_resp_o` = 1.
  - On `advance_i` or `flush_i`: go to IDLE and deassert `dmem_resp_o`.
- **Masks and data** (`a` = `req_addr_i[1:0]`)
  - B/BU: mask = `4'b0001 << a`; `wdata` = `{4{wdata[7:0]}}`.
  - H/HU: mask = `4'b0011 << (2*a[1])`; `wdata` = `{2{wdata[15:0]}}`.
  - W: mask = `4'b1111`; `wdata` unchanged.
  - Loads: `bus_rmask_o` = mask, `bus_wmask_o` = 0.
  - Stores: `bus_wmask_o` = mask, `bus_rmask_o` = 0.
  - For stores, `dmem_rdata_o` captures whatever the bus returns.
- **Protocol assertions**
  - `advance_i` never occurs in REQ or WAIT.
  - `bus_rsp_valid_i` never occurs in IDLE, REQ or DONE.

## Timing
- The op is visible in cycle 0; `bus_req_o` rises in cycle 1.
- With `bus_ready_i` in cycle 1 and `bus_rsp_valid_i` in cycle 2, `dmem_resp_o` and `dmem_rdata_o` are valid in cycle 3. This is the minimum op-to-resp latency: 3 cycles.
- After `advance_i` in DONE, the FSM is in IDLE the next cycle. A back-to-back op therefore issues `bus_req_o` 2 cycles after the `advance_i` edge.
- Bus backpressure extends REQ; response latency extends WAIT. Both are unbounded.
- Reset mid-transaction returns the FSM to IDLE immediately. The bus is reset in the same domain, so no drain is needed.

## Configuration
- Macro: `ORION_LSU_MISALIGN_EN`.
- **Defined:** an access is misaligned when it is H/HU with `a[0]`=1, or W with `a`!=0.
  - In IDLE a misaligned op issues no bus request. The FSM goes directly to DONE with `misalign_o` = 1 and `dmem_rdata_o` = 0.
  - `misalign_o` clears on leaving DONE.
- **Undefined:** `misalign_o` is tied to 0.
  - Unaligned low address bits are ignored as the mask formulas dictate: H uses `a[1]` only; W always uses the full mask.

## Test plan
- **Load word:** LW at `0x1004`, bus ready in cycle 1, response `0xDEADBEEF` in cycle 2 → `bus_addr_o`=`0x1004`, `rmask`=`4'b1111`, `dmem_resp_o`=1 with `dmem_rdata_o`=`0xDEADBEEF` in cycle 3, held until `advance_i`.
- **Store byte:** SB at `0x2003`, data `0x000000A5` → `bus_we_o`=1, `wmask`=`4'b1000`, `bus_wdata_o`=`0xA5A5A5A5`. Repeat SH at `0x2002` → `wmask`=`4'b1100`, `wdata`=`{2{lo16}}`.
- **Backpressure:** hold `bus_ready_i`=0 for 5 cycles → `bus_req_o` and all request fields stable; `dmem_resp_o` stays 0 until the response arrives.
- **Flush in WAIT:** assert `flush_i` in WAIT, then response `0x12345678` → `dmem_resp_o` never rises, FSM returns to IDLE, and the next op issues normally.
- **Reset mid-REQ:** assert `rst_i` while in REQ → `bus_req_o`=0 and `dmem_resp_o`=0 immediately (async), FSM in IDLE.
- **With `ORION_LSU_MISALIGN_EN`:** LW at `0x1002` → no `bus_req_o`; `dmem_resp_o`=1 and `misalign_o`=1 by cycle 1.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: turns the memory op held in EX/MEM into one aligned bus transaction and holds the response for the memory stage.
// Optional feature macro ORION_LSU_MISALIGN_EN: misaligned H/HU/W accesses skip the bus and complete with misalign_o set.
module dmem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_is_load_i,
  input  logic              req_is_store_i,
  input  logic [2:0]        req_type_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic              advance_i,
  input  logic              flush_i,
  output logic              bus_req_o,
  input  logic              bus_ready_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_rmask_o,
  output logic [3:0]        bus_wmask_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_rsp_valid_i,
  input  logic [DATA_W-1:0] bus_rsp_rdata_i,
  output logic [DATA_W-1:0] dmem_rdata_o,
  output logic              dmem_resp_o,
  output logic              misalign_o
);

  localparam logic [2:0] FUNCT3_LS_B  = 3'b000;
  localparam logic [2:0] FUNCT3_LS_H  = 3'b001;
  localparam logic [2:0] FUNCT3_LS_W  = 3'b010;
  localparam logic [2:0] FUNCT3_LS_BU = 3'b100;
  localparam logic [2:0] FUNCT3_LS_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic        kill;
  logic        is_op;
  logic        req_misalign;
  logic [1:0]  a;
  logic [3:0]  lane_mask;
  logic [DATA_W-1:0] lane_wdata;

  assign is_op = req_valid_i && (req_is_load_i || req_is_store_i);
  assign a     = req_addr_i[1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lane_mask  = 4'b1111;
    lane_wdata = req_wdata_i;
    case (req_type_i)
      FUNCT3_LS_B, FUNCT3_LS_BU: begin
        lane_mask  = 4'b0001 << a;
        lane_wdata = {4{req_wdata_i[7:0]}};
      end
      FUNCT3_LS_H, FUNCT3_LS_HU: begin
        lane_mask  = 4'b0011 << {a[1], 1'b0};
        lane_wdata = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef ORION_LSU_MISALIGN_EN
  logic misalign_q;

  always_comb begin
    req_misalign = 1'b0;
    case (req_type_i)
      FUNCT3_LS_H, FUNCT3_LS_HU: req_misalign = a[0];
      FUNCT3_LS_W:               req_misalign = (a != 2'b00);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (state == S_IDLE && is_op && !flush_i && req_misalign) begin
      misalign_q <= 1'b1;
    end else if (state == S_DONE && (advance_i || flush_i)) begin
      misalign_q <= 1'b0;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign req_misalign = 1'b0;
  assign misalign_o   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      kill         <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_rmask_o  <= 4'b0000;
      bus_wmask_o  <= 4'b0000;
      bus_wdata_o  <= '0;
      dmem_rdata_o <= '0;
      dmem_resp_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_op && !flush_i) begin
            if (req_misalign) begin
              dmem_rdata_o <= '0;
              dmem_resp_o  <= 1'b1;
              state        <= S_DONE;
            end else begin
              bus_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              bus_we_o    <= req_is_store_i;
              bus_rmask_o <= req_is_load_i  ? lane_mask : 4'b0000;
              bus_wmask_o <= req_is_store_i ? lane_mask : 4'b0000;
              bus_wdata_o <= lane_wdata;
              bus_req_o   <= 1'b1;
              state       <= S_REQ;
            end
          end
        end
        // A flushed request still completes on the bus; kill only drops its response.
        S_REQ: begin
          if (flush_i) kill <= 1'b1;
          if (bus_ready_i) begin
            bus_req_o <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_rsp_valid_i) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_IDLE;
            end else begin
              dmem_rdata_o <= bus_rsp_rdata_i;
              dmem_resp_o  <= 1'b1;
              state        <= S_DONE;
            end
          end else if (flush_i) begin
            kill <= 1'b1;
          end
        end
        S_DONE: begin
          if (advance_i || flush_i) begin
            dmem_resp_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_ld_st_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
    !(req_is_load_i && req_is_store_i));
  a_no_advance_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    !(advance_i && (state == S_REQ || state == S_WAIT)));
  a_rsp_only_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus_rsp_valid_i && state != S_WAIT));

endmodule
